// File: rtl/wb_xbar_1xn.sv
// wb_xbar_1xn: single-master to NUM_SLAVES-slave Wishbone crossbar with address decode, error response and error counter
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   wbm_*           master-side Wishbone port (adr/dat/we/sel/cyc/stb in, dat/ack/err out)
//   wbs_adr/dat/we/sel_o  broadcast copies of the master request
//   wbs_cyc/stb_o   per-slave cycle/strobe (only the selected slave while BUSY)
//   wbs_dat_i       packed per-slave read data, slice k from slave k
//   wbs_ack_i       per-slave acknowledge
//   err_cnt_o       saturating count of wbm_err_o pulses
// Optional feature: define WB_XBAR_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT_CYCLES cycles.
module wb_xbar_1xn #(
   parameter int NUM_SLAVES = 3,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h1000, 32'h0400, 32'h0200},
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {32'hFFFFF000, 32'hFFFFFFF0, 32'hFFFFFE00},
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        wbm_adr_i,
   input  logic [DATA_W-1:0]        wbm_dat_i,
   input  logic                     wbm_we_i,
   input  logic [DATA_W/8-1:0]      wbm_sel_i,
   input  logic                     wbm_cyc_i,
   input  logic                     wbm_stb_i,
   output logic [DATA_W-1:0]        wbm_dat_o,
   output logic                     wbm_ack_o,
   output logic                     wbm_err_o,
   output logic [ADDR_W-1:0]        wbs_adr_o,
   output logic [DATA_W-1:0]        wbs_dat_o,
   output logic                     wbs_we_o,
   output logic [DATA_W/8-1:0]      wbs_sel_o,
   output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
   output logic [NUM_SLAVES-1:0]    wbs_stb_o,
   input  logic [NUM_SLAVES*DATA_W-1:0] wbs_dat_i,
   input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
   output logic [7:0]               err_cnt_o
);
   localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
   state_t state;
   logic [SW-1:0] sel_q, hit_idx;
   logic hit, busy;
`ifdef WB_XBAR_TIMEOUT_EN
   logic [15:0] wd_q;
`endif
   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      for (int k = NUM_SLAVES - 1; k >= 0; k--)
         if ((wbm_adr_i & SLAVE_MASK[k*ADDR_W +: ADDR_W]) == (SLAVE_BASE[k*ADDR_W +: ADDR_W] & SLAVE_MASK[k*ADDR_W +: ADDR_W])) begin
            hit = 1'b1;
            hit_idx = SW'(k);
         end
   end
   assign busy = state == BUSY;
   assign wbs_adr_o = wbm_adr_i;
   assign wbs_dat_o = wbm_dat_i;
   assign wbs_we_o = wbm_we_i;
   assign wbs_sel_o = wbm_sel_i;
   assign wbs_cyc_o = busy ? NUM_SLAVES'(wbm_cyc_i) << sel_q : '0;
   assign wbs_stb_o = busy ? NUM_SLAVES'(wbm_stb_i) << sel_q : '0;
   // Gating with wbm_cyc_i keeps an abort cycle silent even if the slave acks late.
   assign wbm_ack_o = busy & wbm_cyc_i & wbs_ack_i[sel_q];
   assign wbm_dat_o = busy ? wbs_dat_i[sel_q*DATA_W +: DATA_W] : '0;
   assign wbm_err_o = state == ERR;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         sel_q <= '0;
         err_cnt_o <= '0;
`ifdef WB_XBAR_TIMEOUT_EN
         wd_q <= '0;
`endif
      end else begin
         unique case (state)
            IDLE:
               if (wbm_cyc_i & wbm_stb_i) begin
                  if (hit) sel_q <= hit_idx;
                  state <= hit ? BUSY : ERR;
               end
            BUSY:
               if (!wbm_cyc_i || wbm_ack_o) state <= IDLE;
`ifdef WB_XBAR_TIMEOUT_EN
               else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) state <= ERR;
`endif
            default: state <= IDLE;
         endcase
         if (wbm_err_o && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
`ifdef WB_XBAR_TIMEOUT_EN
         // Zero outside BUSY, so it is already clear on entry to BUSY.
         wd_q <= busy ? wd_q + 16'd1 : '0;
`endif
      end
endmodule

// File: tb/tb_wb_xbar_1xn.sv
// tb_wb_xbar_1xn: directed table-driven bench for wb_xbar_1xn
module tb_wb_xbar_1xn;
   logic clk = 0, rst = 1;
   logic [31:0] wbm_adr_i = 0, wbm_dat_i = 0, wbm_dat_o, wbs_adr_o, wbs_dat_o;
   logic wbm_we_i = 0, wbm_cyc_i = 0, wbm_stb_i = 0, wbm_ack_o, wbm_err_o, wbs_we_o;
   logic [3:0] wbm_sel_i = 0, wbs_sel_o;
   logic [2:0] wbs_cyc_o, wbs_stb_o, wbs_ack_i = 0;
   logic [95:0] wbs_dat_i = 0;
   logic [7:0] err_cnt_o;
   int checks = 0, errors = 0, exp_cnt = 0;

`ifdef WB_XBAR_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   wb_xbar_1xn #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i),
      .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o),
      .wbm_err_o(wbm_err_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_we_o(wbs_we_o),
      .wbs_sel_o(wbs_sel_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_i(wbs_ack_i), .err_cnt_o(err_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] wdat;
      int          dly;
      logic [31:0] rdat;
      logic [2:0]  stb;
      logic [2:0]  stray;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_bus();
      wbm_cyc_i = 0;
      wbm_stb_i = 0;
      wbs_ack_i = 0;
   endtask

   task automatic request(input logic [31:0] adr, input logic we, input logic [31:0] wdat);
      @(negedge clk);
      wbm_adr_i = adr;
      wbm_we_i = we;
      wbm_dat_i = wdat;
      wbm_sel_i = 4'hF;
      wbm_cyc_i = 1;
      wbm_stb_i = 1;
      #1;
      chk("idle_stb", wbs_stb_o, 0);
      chk("idle_ack", wbm_ack_o, 0);
      chk("adr_copy", wbs_adr_o, adr);
      chk("dat_copy", wbs_dat_o, wdat);
      chk("we_copy", wbs_we_o, we);
      chk("sel_copy", wbs_sel_o, 4'hF);
   endtask

   initial begin
      vecs[0] = '{32'h204,  0, 32'h0,  0, 32'hDEADBEEF, 3'b001, 3'b000};
      vecs[1] = '{32'h400,  1, 32'hA5, 2, 32'h11111111, 3'b010, 3'b000};
      vecs[2] = '{32'h800,  0, 32'h0,  0, 32'h0,        3'b000, 3'b000};
      vecs[3] = '{32'h1004, 0, 32'h0,  1, 32'h12345678, 3'b100, 3'b011};
      vecs[4] = '{32'h3FC,  0, 32'h0,  0, 32'hCAFEF00D, 3'b001, 3'b110};
      vecs[5] = '{32'h40F,  1, 32'h5A, 0, 32'h0BADCAFE, 3'b010, 3'b101};
      vecs[6] = '{32'h410,  0, 32'h0,  0, 32'h0,        3'b000, 3'b000};
      vecs[7] = '{32'h1FFF, 0, 32'h0,  3, 32'h87654321, 3'b100, 3'b001};
      vecs[8] = '{32'h0,    1, 32'h7,  0, 32'h0,        3'b000, 3'b000};

      #1;
      chk("rst_stb", wbs_stb_o, 0);
      chk("rst_cyc", wbs_cyc_o, 0);
      chk("rst_ack", wbm_ack_o, 0);
      chk("rst_err", wbm_err_o, 0);
      chk("rst_cnt", err_cnt_o, 0);
      @(negedge clk);
      rst = 0;

      foreach (vecs[i]) begin
         request(vecs[i].adr, vecs[i].we, vecs[i].wdat);
         if (vecs[i].stb == 0) begin
            @(negedge clk);
            #1;
            chk("miss_err", wbm_err_o, 1);
            chk("miss_stb", wbs_stb_o, 0);
            chk("miss_ack", wbm_ack_o, 0);
            exp_cnt++;
         end else begin
            for (int k = 0; k <= vecs[i].dly; k++) begin
               @(negedge clk);
               wbs_dat_i = {32'hBAD00002, 32'hBAD00001, 32'hBAD00000};
               for (int s = 0; s < 3; s++)
                  if (vecs[i].stb[s]) wbs_dat_i[s*32 +: 32] = vecs[i].rdat;
               wbs_ack_i = (k == vecs[i].dly ? vecs[i].stb : 3'b000) | vecs[i].stray;
               #1;
               chk("busy_stb", wbs_stb_o, vecs[i].stb);
               chk("busy_cyc", wbs_cyc_o, vecs[i].stb);
               chk("busy_err", wbm_err_o, 0);
               chk("busy_ack", wbm_ack_o, k == vecs[i].dly);
               if (k == vecs[i].dly) chk("rd_dat", wbm_dat_o, vecs[i].rdat);
            end
         end
         @(negedge clk);
         idle_bus();
         #1;
         chk("post_ack", wbm_ack_o, 0);
         chk("post_err", wbm_err_o, 0);
         chk("post_dat", wbm_dat_o, 0);
         chk("post_stb", wbs_stb_o, 0);
         chk("err_cnt", err_cnt_o, exp_cnt);
      end

      // Abort: master drops cyc in BUSY while the slave acks.
      request(32'h208, 0, 0);
      @(negedge clk);
      #1;
      chk("abort_stb_before", wbs_stb_o, 3'b001);
      wbm_cyc_i = 0;
      wbm_stb_i = 0;
      wbs_ack_i = 3'b001;
      #1;
      chk("abort_stb", wbs_stb_o, 0);
      chk("abort_cyc", wbs_cyc_o, 0);
      chk("abort_ack", wbm_ack_o, 0);
      @(negedge clk);
      wbs_ack_i = 0;
      #1;
      chk("abort_err", wbm_err_o, 0);
      chk("abort_idle_stb", wbs_stb_o, 0);

      // Slave 2 never acks.
      request(32'h1000, 0, 0);
`ifdef WB_XBAR_TIMEOUT_EN
      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         #1;
         chk("to_busy_stb", wbs_stb_o, 3'b100);
         chk("to_busy_err", wbm_err_o, 0);
      end
      @(negedge clk);
      #1;
      chk("to_err", wbm_err_o, 1);
      chk("to_stb", wbs_stb_o, 0);
      chk("to_ack", wbm_ack_o, 0);
      exp_cnt++;
      @(negedge clk);
      idle_bus();
      #1;
      chk("to_err_end", wbm_err_o, 0);
      chk("to_cnt", err_cnt_o, exp_cnt);
`else
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         #1;
         chk("wait_stb", wbs_stb_o, 3'b100);
         chk("wait_err", wbm_err_o, 0);
      end
      @(negedge clk);
      idle_bus();
      #1;
      chk("wait_abort_stb", wbs_stb_o, 0);
      @(negedge clk);
      #1;
      chk("wait_cnt", err_cnt_o, exp_cnt);
`endif

      // 300 back-to-back decode misses saturate the counter.
      @(negedge clk);
      wbm_adr_i = 32'h800;
      wbm_cyc_i = 1;
      wbm_stb_i = 1;
      repeat (600) @(negedge clk);
      idle_bus();
      #1;
      chk("sat_cnt", err_cnt_o, 255);
      @(negedge clk);
      #1;
      chk("sat_hold", err_cnt_o, 255);

      // Reset in the middle of a BUSY cycle.
      request(32'h204, 0, 0);
      @(negedge clk);
      #1;
      chk("rst_busy_stb", wbs_stb_o, 3'b001);
      wbs_ack_i = 3'b001;
      #1;
      rst = 1;
      #1;
      chk("rst_mid_stb", wbs_stb_o, 0);
      chk("rst_mid_cyc", wbs_cyc_o, 0);
      chk("rst_mid_ack", wbm_ack_o, 0);
      chk("rst_mid_err", wbm_err_o, 0);
      chk("rst_mid_cnt", err_cnt_o, 0);
      @(negedge clk);
      idle_bus();
      rst = 0;
      #1;
      chk("rst_rel_stb", wbs_stb_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
